mel_log_compress: RTL and testbench

- Consumes one frame of mel filterbank energies, presented as NUM_FILTERS parallel 32-bit words with a valid/ready handshake, directly from mel_filterbank.
- Serialises the frame and emits one unsigned fixed-point log2 approximation per filter as a valid/ready/last stream.
- Log2 uses Mitchell's approximation: leading-one position gives the integer part; the bits below the leading one, left-aligned, give the fraction.
- Its output feeds the downstream DCT/MFCC stage.

---
 rtl/mel_log_compress.sv | 148 ++++++++++++++
 tb/tb_mel_log_compress.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mel_log_compress.sv
// mel_log_compress: takes one frame of mel filterbank energies in a single
// valid/ready transfer, buffers it, and emits one Q5.11 log2 value per filter
// as a valid/ready/last stream. log2 uses Mitchell's approximation: the
// leading-one position is the integer part, and the bits below it,
// left-aligned, are the fraction.
//
// Handshake semantics (both ports): a transfer happens on a rising edge where
// valid and ready are both high. A producer holding valid keeps its payload
// stable until the transfer. Reset dominates every handshake in the same cycle.
module mel_log_compress #(
  parameter int NUM_FILTERS = 26,
  parameter int DATA_WIDTH  = 32,
  parameter int INT_BITS    = 5,   // must equal $clog2(DATA_WIDTH)
  parameter int FRAC_BITS   = 11   // must not exceed DATA_WIDTH
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic [DATA_WIDTH-1:0]         filtered_data_in [NUM_FILTERS],
  input  logic                          filtered_valid_in,
  output logic                          filtered_ready_out,
  output logic [INT_BITS+FRAC_BITS-1:0] log_data_out,
  output logic                          log_valid_out,
  output logic                          log_last_out,
  input  logic                          log_ready_in,
  output logic [1:0]                    dbg_state_out
);

  localparam int IDX_W = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;
  localparam int SHW   = INT_BITS + 1;
  localparam int OUT_W = INT_BITS + FRAC_BITS;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FILTERS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EMIT = 2'd1
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [DATA_WIDTH-1:0] r_buf [NUM_FILTERS];
  logic [IDX_W-1:0]      r_idx;
  logic [IDX_W-1:0]      w_next_idx;
  logic                  r_ready;
  logic                  r_valid;
  logic                  r_last;
  logic [OUT_W-1:0]      r_data;

  logic                  w_accept;
  logic                  w_hs;
  logic                  w_frame_done;
  logic [DATA_WIDTH-1:0] w_src;
  logic [INT_BITS-1:0]   w_p;
  logic [SHW-1:0]        w_shamt;
  logic [FRAC_BITS-1:0]  w_frac;
  logic [OUT_W-1:0]      w_log;

  // Handshake qualifiers and the index of the word that will be loaded next.
  always_comb begin
    w_accept     = (r_state == S_IDLE) && filtered_valid_in && r_ready;
    w_hs         = (r_state == S_EMIT) && r_valid && log_ready_in;
    w_frame_done = w_hs && (r_idx == LAST_IDX);
    w_next_idx   = (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
  end

  // Single log2 datapath: in IDLE it sees input word 0, in EMIT the next
  // buffered word, so only one priority encoder is needed.
  always_comb begin
    w_src = (r_state == S_IDLE) ? filtered_data_in[0] : r_buf[w_next_idx];
  end

  // Priority encoder: position of the most significant 1 (0 for x == 0 or 1).
  always_comb begin
    w_p = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (w_src[i]) w_p = INT_BITS'(i);
    end
  end

  // Fraction: shift the leading one out of the top, keep the top FRAC_BITS.
  // Short mantissas are zero-padded, long ones truncated, no rounding.
  always_comb begin
    w_shamt = SHW'(DATA_WIDTH) - SHW'(w_p);
    w_frac  = FRAC_BITS'((w_src << w_shamt) >> (DATA_WIDTH - FRAC_BITS));
    w_log   = {w_p, w_frac};
  end

  // FSM state register.
  always_ff @(posedge clk_in) begin
    if (rst_in) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // FSM next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_accept)     w_next_state = S_EMIT;
      S_EMIT:  if (w_frame_done) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Frame buffer: captured on accept, untouched while emitting so upstream
  // changes during EMIT are ignored. No reset needed; it is always written
  // before it is read.
  always_ff @(posedge clk_in) begin
    if (!rst_in && w_accept) r_buf <= filtered_data_in;
  end

  // Registered stream outputs, index counter and upstream ready.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_ready <= 1'b0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_data  <= '0;
      r_idx   <= '0;
    end else begin
      // Ready tracks the state being entered, so it is high exactly in IDLE
      // (and rises on the first edge after reset).
      r_ready <= (w_next_state == S_IDLE);
      if (w_accept) begin
        r_data  <= w_log;
        r_valid <= 1'b1;
        r_last  <= (NUM_FILTERS == 1);
        r_idx   <= '0;
      end else if (w_frame_done) begin
        r_valid <= 1'b0;
        r_last  <= 1'b0;
        r_idx   <= '0;
      end else if (w_hs) begin
        r_idx   <= w_next_idx;
        r_data  <= w_log;
        r_last  <= (w_next_idx == LAST_IDX);
      end
    end
  end

  // FSM output logic: ports are driven straight from registers.
  always_comb begin
    filtered_ready_out = r_ready;
    log_data_out       = r_data;
    log_valid_out      = r_valid;
    log_last_out       = r_last;
    dbg_state_out      = r_state;
  end

endmodule

// File: tb/tb_mel_log_compress.sv
// Directed bench for mel_log_compress: fixed frames with hand-computed log2
// values, a scoreboard queue of expected {last, data} words, and a small
// bit-by-bit Mitchell model for the sine-squared and backpressure frames.
module tb_mel_log_compress;

  localparam int N = 26;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic [31:0] filtered_data_in [N];
  logic        filtered_valid_in = 1'b0;
  logic        filtered_ready_out;
  logic [15:0] log_data_out;
  logic        log_valid_out;
  logic        log_last_out;
  logic        log_ready_in = 1'b0;
  logic [1:0]  dbg_state_out;

  logic [31:0] exp_q[$];   // {15'b0, last, data} per expected word
  int n_vec = 0;
  int n_err = 0;
  int n_hs  = 0;

  mel_log_compress dut (
    .clk_in             (clk_in),
    .rst_in             (rst_in),
    .filtered_data_in   (filtered_data_in),
    .filtered_valid_in  (filtered_valid_in),
    .filtered_ready_out (filtered_ready_out),
    .log_data_out       (log_data_out),
    .log_valid_out      (log_valid_out),
    .log_last_out       (log_last_out),
    .log_ready_in       (log_ready_in),
    .dbg_state_out      (dbg_state_out)
  );

  // Clock and watchdog.
  always #5 clk_in = ~clk_in;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Mitchell log2 reference, built bit by bit from the leading-one position.
  function automatic logic [15:0] mitchell(input logic [31:0] x);
    int p;
    logic [10:0] f;
    p = 0;
    f = '0;
    for (int i = 0; i < 32; i++) if (x[i]) p = i;
    for (int b = 0; b < 11; b++) begin
      if (p - 1 - b >= 0) f[10 - b] = x[p - 1 - b];
    end
    return {p[4:0], f};
  endfunction

  function automatic logic [31:0] exp_word(input int i, input logic [15:0] d);
    return {15'b0, (i == N - 1), d};
  endfunction

  // One clock: score the handshake / stall seen before the edge, then
  // advance to 1 time unit after the edge.
  task automatic step();
    logic        hs;
    logic        stall;
    logic [15:0] d0;
    logic        l0;
    logic [31:0] e;
    hs    = log_valid_out && log_ready_in && !rst_in;
    stall = log_valid_out && !log_ready_in && !rst_in;
    d0    = log_data_out;
    l0    = log_last_out;
    if (hs) begin
      n_hs++;
      if (exp_q.size() == 0) check("extra_word", 32'({l0, d0}), 32'hDEAD_BEEF);
      else begin
        e = exp_q.pop_front();
        check("word", {15'b0, l0, d0}, e);
      end
    end
    @(posedge clk_in);
    #1;
    if (stall) check("stall_hold", 32'({log_valid_out, log_last_out, log_data_out}),
                     32'({1'b1, l0, d0}));
  endtask

  // Present a frame, wait (bounded) for ready, take the accept edge.
  task automatic send_frame(input logic [31:0] w [N]);
    int n;
    filtered_data_in  = w;
    filtered_valid_in = 1'b1;
    n = 0;
    while (!filtered_ready_out && n < 100) begin
      step();
      n++;
    end
    if (!filtered_ready_out) check("accept_timeout", 32'(filtered_ready_out), 32'd1);
    step();
    filtered_valid_in = 1'b0;
  endtask

  // Drain the scoreboard. mode 0: ready always high; 1: ready toggles;
  // 2: toggles, with a 5-cycle low stretch mid-frame.
  task automatic drain(input int mode, output int steps);
    steps = 0;
    while (exp_q.size() > 0 && steps < 1000) begin
      case (mode)
        0:       log_ready_in = 1'b1;
        1:       log_ready_in = (steps % 2 == 0);
        default: log_ready_in = (steps >= 12 && steps < 17) ? 1'b0 : (steps % 2 == 0);
      endcase
      step();
      steps++;
    end
    if (exp_q.size() != 0) check("drain_timeout", 32'(exp_q.size()), 32'd0);
    log_ready_in = 1'b1;
  endtask

  logic [31:0] w_a [N];
  logic [31:0] w_b [N];
  int steps;
  int hs0;
  int viol;

  initial begin
    for (int i = 0; i < N; i++) filtered_data_in[i] = '0;

    // Reset state.
    rst_in = 1'b1;
    @(posedge clk_in); #1;
    @(posedge clk_in); #1;
    check("rst_ready", 32'(filtered_ready_out), 32'd0);
    check("rst_valid", 32'(log_valid_out), 32'd0);
    check("rst_last",  32'(log_last_out), 32'd0);
    check("rst_data",  32'(log_data_out), 32'd0);
    check("rst_state", 32'(dbg_state_out), 32'd0);
    rst_in = 1'b0;
    step();
    check("ready_after_rst", 32'(filtered_ready_out), 32'd1);

    // Frame of 0x0000BEEF: p = 15, fraction = 0b01111101110 -> 0x7BEE.
    log_ready_in = 1'b1;
    for (int i = 0; i < N; i++) begin
      w_a[i] = 32'h0000_BEEF;
      exp_q.push_back(exp_word(i, 16'h7BEE));
    end
    send_frame(w_a);
    check("first_latency_valid", 32'(log_valid_out), 32'd1);
    check("emit_ready_low", 32'(filtered_ready_out), 32'd0);
    check("emit_state", 32'(dbg_state_out), 32'd1);
    drain(0, steps);
    check("beef_cycles", 32'(steps), 32'd26);
    check("ready_back", 32'(filtered_ready_out), 32'd1);
    check("valid_cleared", 32'(log_valid_out), 32'd0);

    // Boundary words.
    w_a[0] = 32'd0;          w_a[1] = 32'd1;          w_a[2] = 32'd2;
    w_a[3] = 32'd3;          w_a[4] = 32'h8000_0000;  w_a[5] = 32'hFFFF_FFFF;
    for (int i = 6; i < N; i++) w_a[i] = 32'h0000_0400;
    exp_q.push_back(exp_word(0, 16'h0000));
    exp_q.push_back(exp_word(1, 16'h0000));
    exp_q.push_back(exp_word(2, 16'h0800));
    exp_q.push_back(exp_word(3, 16'h0C00));
    exp_q.push_back(exp_word(4, 16'hF800));
    exp_q.push_back(exp_word(5, 16'hFFFF));
    for (int i = 6; i < N; i++) exp_q.push_back(exp_word(i, 16'h5000));
    send_frame(w_a);
    drain(0, steps);

    // Backpressure: toggling ready plus a 5-cycle stall.
    for (int i = 0; i < N; i++) begin
      w_a[i] = (i + 1) * 32'h0001_2345;
      exp_q.push_back(exp_word(i, mitchell(w_a[i])));
    end
    send_frame(w_a);
    hs0 = n_hs;
    drain(2, steps);
    check("bp_handshakes", 32'(n_hs - hs0), 32'd26);

    // Second frame held valid during EMIT; 0x12345678 -> p = 28, frac 0x11A.
    for (int i = 0; i < N; i++) begin
      w_a[i] = 32'd1 << (i + 1);
      w_b[i] = 32'h1234_5678;
      exp_q.push_back(exp_word(i, 16'((i + 1) * 16'h0800)));
    end
    send_frame(w_a);
    filtered_data_in  = w_b;
    filtered_valid_in = 1'b1;
    viol = 0;
    while (exp_q.size() > 0 && viol < 1000) begin
      if (filtered_ready_out) viol++;
      step();
    end
    check("held_ready_low", 32'(viol), 32'd0);
    check("held_not_accepted", 32'(log_valid_out), 32'd0);
    for (int i = 0; i < N; i++) exp_q.push_back(exp_word(i, 16'hE11A));
    step();
    filtered_valid_in = 1'b0;
    check("second_accept", 32'(log_valid_out), 32'd1);
    drain(0, steps);

    // Reset after 10 words; the rest of the frame is discarded.
    for (int i = 0; i < N; i++) exp_q.push_back(exp_word(i, 16'((i + 1) * 16'h0800)));
    send_frame(w_a);
    for (int i = 0; i < 10; i++) step();
    exp_q.delete();
    rst_in = 1'b1;
    step();
    rst_in = 1'b0;
    check("rst_mid_valid", 32'(log_valid_out), 32'd0);
    check("rst_mid_ready", 32'(filtered_ready_out), 32'd0);
    check("rst_mid_last",  32'(log_last_out), 32'd0);
    step();
    check("rst_mid_ready_back", 32'(filtered_ready_out), 32'd1);
    for (int i = 0; i < N; i++) exp_q.push_back(exp_word(i, 16'((i + 1) * 16'h0800)));
    send_frame(w_a);
    drain(1, steps);

    // Sine-squared frame against the Mitchell model.
    for (int i = 0; i < N; i++) begin
      real s;
      s = $sin(real'(i) / 5.0);
      w_a[i] = 32'($rtoi(61453.0 * s * s));
      exp_q.push_back(exp_word(i, mitchell(w_a[i])));
    end
    send_frame(w_a);
    drain(0, steps);
    check("sine_cycles", 32'(steps), 32'd26);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
